mbus_node_rx: RTL and testbench

- Member-node receive stage directly downstream of the bus master control block; consumes the bus clock and bus data that the master drives onto the ring.
- Oversamples both lines on the local system clock and detects the start of a message.
- Skips the arbitration edge, shifts in an address field and filters it against the node address or the broadcast address.
- Delivers matched payload bytes to the layer controller over a valid/ack handshake and reports end-of-message, error and overflow.

---
 rtl/mbus_node_rx.sv | 232 +++++++++++++++++++++++
 tb/tb_mbus_node_rx.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mbus_node_rx.sv
// rtl/mbus_node_rx.sv - member-node receive stage: start detect, address filter, byte delivery
//
// Oversamples the master's bus clock/data on CLK_IN, detects a message start
// (data low while clock high), discards the arbitration edges, shifts in an
// ADDR_WIDTH-bit address and accepts the message when it equals NODE_ADDR or
// BCAST_ADDR. Accepted payload bytes are handed to the layer controller over
// a valid/ack handshake.
//
// Ports:
//   CLK_IN    in   system clock, rising edge
//   RESET     in   synchronous active-high reset
//   BUS_CLK   in   bus clock from the master (asynchronous)
//   BUS_DIN   in   bus data from the master (asynchronous)
//   RX_DATA   out  received payload byte
//   RX_VALID  out  RX_DATA holds an unconsumed byte
//   RX_ACK    in   layer consumes RX_DATA (only meaningful while RX_VALID=1)
//   RX_BCAST  out  current/last message was addressed to BCAST_ADDR
//   RX_END    out  one-cycle pulse at end of an accepted message
//   RX_ERR    out  one-cycle pulse with RX_END when the last byte was partial
//   RX_OVF    out  sticky: a byte completed while RX_VALID=1; cleared at next start

module mbus_node_rx #(
    parameter int                    ADDR_WIDTH = 4,
    parameter logic [ADDR_WIDTH-1:0] NODE_ADDR  = 4'h3,
    parameter logic [ADDR_WIDTH-1:0] BCAST_ADDR = 4'hF,
    parameter int                    SKIP_EDGES = 1,
    parameter int                    END_IDLE   = 40
) (
    input  logic       CLK_IN,
    input  logic       RESET,
    input  logic       BUS_CLK,
    input  logic       BUS_DIN,
    output logic [7:0] RX_DATA,
    output logic       RX_VALID,
    input  logic       RX_ACK,
    output logic       RX_BCAST,
    output logic       RX_END,
    output logic       RX_ERR,
    output logic       RX_OVF
);

    localparam int EW = $clog2(SKIP_EDGES + 1);
    localparam int IW = $clog2(END_IDLE + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_ADDR,
        S_DATA,
        S_SKIP
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Synchronizers idle high so a reset never looks like a start condition.
    logic r_clk_s1, r_clk_s2, r_clk_d;
    logic r_din_s1, r_din_s2;

    logic [EW-1:0]         r_edge_cnt;
    logic [3:0]            r_bit_cnt;
    logic [IW-1:0]         r_idle_cnt;
    logic [ADDR_WIDTH-1:0] r_addr_sr;
    logic [7:0]            r_byte_sr;

    logic [7:0] r_rx_data;
    logic       r_rx_valid;
    logic       r_rx_bcast;
    logic       r_rx_end;
    logic       r_rx_err;
    logic       r_rx_ovf;

    logic                  w_rise;
    logic                  w_start;
    logic                  w_idle_done;
    logic                  w_addr_last;
    logic                  w_byte_done;
    logic [ADDR_WIDTH-1:0] w_addr_next;
    logic [7:0]            w_byte_next;

    assign w_rise      = r_clk_s2 & ~r_clk_d;
    assign w_start     = r_clk_s2 & ~r_din_s2;
    // The bus clock has been high for END_IDLE consecutive cycles: the
    // master has stopped toggling, so the message is over.
    assign w_idle_done = (r_state != S_IDLE) && r_clk_s2 &&
                         (r_idle_cnt == IW'(END_IDLE - 1));
    assign w_addr_next = {r_addr_sr[ADDR_WIDTH-2:0], r_din_s2};
    assign w_byte_next = {r_byte_sr[6:0], r_din_s2};
    assign w_addr_last = (r_bit_cnt == 4'(ADDR_WIDTH - 1));
    assign w_byte_done = (r_state == S_DATA) && w_rise && !w_idle_done &&
                         (r_bit_cnt == 4'd7);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_next = S_ARB;
                end
            end
            S_ARB: begin
                if (w_idle_done) begin
                    w_state_next = S_IDLE;
                end else if (w_rise && (r_edge_cnt == EW'(SKIP_EDGES - 1))) begin
                    w_state_next = S_ADDR;
                end
            end
            S_ADDR: begin
                if (w_idle_done) begin
                    w_state_next = S_IDLE;
                end else if (w_rise && w_addr_last) begin
                    if ((w_addr_next == NODE_ADDR) || (w_addr_next == BCAST_ADDR)) begin
                        w_state_next = S_DATA;
                    end else begin
                        w_state_next = S_SKIP;
                    end
                end
            end
            S_DATA, S_SKIP: begin
                if (w_idle_done) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK_IN) begin
        if (RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge CLK_IN) begin
        if (RESET) begin
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_clk_d    <= 1'b1;
            r_din_s1   <= 1'b1;
            r_din_s2   <= 1'b1;
            r_edge_cnt <= '0;
            r_bit_cnt  <= '0;
            r_idle_cnt <= '0;
            r_addr_sr  <= '0;
            r_byte_sr  <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_rx_bcast <= 1'b0;
            r_rx_end   <= 1'b0;
            r_rx_err   <= 1'b0;
            r_rx_ovf   <= 1'b0;
        end else begin
            r_clk_s1 <= BUS_CLK;
            r_clk_s2 <= r_clk_s1;
            r_clk_d  <= r_clk_s2;
            r_din_s1 <= BUS_DIN;
            r_din_s2 <= r_din_s1;

            r_rx_end <= 1'b0;
            r_rx_err <= 1'b0;

            if ((r_state == S_IDLE) || !r_clk_s2 || w_idle_done) begin
                r_idle_cnt <= '0;
            end else if (r_idle_cnt != IW'(END_IDLE)) begin
                r_idle_cnt <= r_idle_cnt + 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_edge_cnt <= '0;
                        r_bit_cnt  <= '0;
                        r_rx_ovf   <= 1'b0;
                        r_rx_bcast <= 1'b0;
                    end
                end
                S_ARB: begin
                    if (w_rise && !w_idle_done && (r_edge_cnt != EW'(SKIP_EDGES))) begin
                        r_edge_cnt <= r_edge_cnt + 1'b1;
                    end
                end
                S_ADDR: begin
                    if (w_rise && !w_idle_done) begin
                        r_addr_sr <= w_addr_next;
                        if (w_addr_last) begin
                            r_bit_cnt <= '0;
                            if (w_addr_next == BCAST_ADDR) begin
                                r_rx_bcast <= 1'b1;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end
                    end
                end
                S_DATA: begin
                    if (w_idle_done) begin
                        // A partial byte is flagged and simply left in byte_sr.
                        r_rx_end <= 1'b1;
                        r_rx_err <= (r_bit_cnt != 4'd0);
                    end else if (w_rise) begin
                        r_byte_sr <= w_byte_next;
                        r_bit_cnt <= (r_bit_cnt == 4'd7) ? 4'd0 : r_bit_cnt + 4'd1;
                    end
                end
                default: ;
            endcase

            // An ack arriving with a new byte frees the holding register in
            // the same cycle, so the new byte is taken without overflow.
            if (w_byte_done) begin
                if (!r_rx_valid || RX_ACK) begin
                    r_rx_data  <= w_byte_next;
                    r_rx_valid <= 1'b1;
                end else begin
                    r_rx_ovf <= 1'b1;
                end
            end else if (r_rx_valid && RX_ACK) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    assign RX_DATA  = r_rx_data;
    assign RX_VALID = r_rx_valid;
    assign RX_BCAST = r_rx_bcast;
    assign RX_END   = r_rx_end;
    assign RX_ERR   = r_rx_err;
    assign RX_OVF   = r_rx_ovf;

endmodule

// File: tb/tb_mbus_node_rx.sv
// tb/tb_mbus_node_rx.sv - directed vector bench for mbus_node_rx
module tb_mbus_node_rx;

    localparam int H        = 6;
    localparam int END_IDLE = 40;

    logic       CLK_IN;
    logic       RESET;
    logic       BUS_CLK;
    logic       BUS_DIN;
    logic [7:0] RX_DATA;
    logic       RX_VALID;
    logic       RX_ACK;
    logic       RX_BCAST;
    logic       RX_END;
    logic       RX_ERR;
    logic       RX_OVF;

    logic man_ack;
    logic auto_pulse;
    logic auto_en;
    assign RX_ACK = man_ack | auto_pulse;

    int n_cmp = 0;
    int n_bad = 0;
    int end_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;
    logic [7:0] rxq[$];

    mbus_node_rx #(
        .ADDR_WIDTH(4),
        .NODE_ADDR (4'h3),
        .BCAST_ADDR(4'hF),
        .SKIP_EDGES(1),
        .END_IDLE  (END_IDLE)
    ) dut (
        .CLK_IN  (CLK_IN),
        .RESET   (RESET),
        .BUS_CLK (BUS_CLK),
        .BUS_DIN (BUS_DIN),
        .RX_DATA (RX_DATA),
        .RX_VALID(RX_VALID),
        .RX_ACK  (RX_ACK),
        .RX_BCAST(RX_BCAST),
        .RX_END  (RX_END),
        .RX_ERR  (RX_ERR),
        .RX_OVF  (RX_OVF)
    );

    initial begin
        CLK_IN = 1'b0;
        forever #5 CLK_IN = ~CLK_IN;
    end

    // Layer-side model: counts end/err pulses and, when enabled, acks each
    // byte one cycle after it appears, logging it.
    initial begin
        auto_pulse = 1'b0;
        forever begin
            @(negedge CLK_IN);
            if (RX_END) end_cnt++;
            if (RX_ERR) err_cnt++;
            if (RX_END && RX_ERR) both_cnt++;
            if (auto_en && RX_VALID && !auto_pulse) begin
                rxq.push_back(RX_DATA);
                auto_pulse = 1'b1;
            end else begin
                auto_pulse = 1'b0;
            end
        end
    end

    typedef struct {
        logic [3:0]  addr;
        int          nbytes;
        logic [23:0] bytes;
        int          extra_n;
        logic [7:0]  extra_pat;
        bit          ack;
        int          exp_n;
        logic [7:0]  exp_b0;
        logic [7:0]  exp_b1;
        int          exp_end;
        int          exp_err;
        bit          exp_bcast;
        bit          exp_ovf;
        bit          exp_valid;
        logic [7:0]  exp_data;
    } vec_t;

    vec_t vecs[9];
    vec_t post_rst;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge CLK_IN);
    endtask

    task automatic send_bit(input logic b, input int hi);
        BUS_CLK = 1'b0;
        BUS_DIN = b;
        wait_cyc(H);
        BUS_CLK = 1'b1;
        wait_cyc(hi);
    endtask

    task automatic send_bits(input logic [7:0] pat, input int n);
        for (int i = 0; i < n; i++) send_bit(pat[7-i], H);
    endtask

    task automatic send_head(input logic [3:0] addr);
        BUS_DIN = 1'b0;
        wait_cyc(H);
        send_bit(1'b1, H);
        send_bits({addr, 4'h0}, 4);
    endtask

    task automatic send_tail();
        BUS_DIN = 1'b1;
        wait_cyc(60);
    endtask

    task automatic send_msg(input logic [3:0] addr, input int nbytes, input logic [23:0] bytes,
                            input int extra_n, input logic [7:0] extra_pat);
        send_head(addr);
        for (int k = 0; k < nbytes; k++) send_bits(bytes[23-8*k -: 8], 8);
        if (extra_n > 0) send_bits(extra_pat, extra_n);
        send_tail();
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int q0, e0, r0, b0;
        q0 = rxq.size();
        e0 = end_cnt;
        r0 = err_cnt;
        b0 = both_cnt;
        auto_en = v.ack;
        wait_cyc(8);
        send_msg(v.addr, v.nbytes, v.bytes, v.extra_n, v.extra_pat);
        wait_cyc(4);
        chk({tag, " nrx"}, rxq.size() - q0, v.exp_n);
        if (v.exp_n > 0 && rxq.size() > q0) chk({tag, " byte0"}, rxq[q0], v.exp_b0);
        if (v.exp_n > 1 && rxq.size() > q0 + 1) chk({tag, " byte1"}, rxq[q0+1], v.exp_b1);
        chk({tag, " end"}, end_cnt - e0, v.exp_end);
        chk({tag, " err"}, err_cnt - r0, v.exp_err);
        chk({tag, " err_with_end"}, both_cnt - b0, v.exp_err);
        chk({tag, " bcast"}, RX_BCAST, v.exp_bcast);
        chk({tag, " ovf"}, RX_OVF, v.exp_ovf);
        chk({tag, " valid"}, RX_VALID, v.exp_valid);
        if (v.exp_valid) chk({tag, " data"}, RX_DATA, v.exp_data);
        auto_en = 1'b0;
    endtask

    initial begin
        int e0, r0, q0;
        RESET   = 1'b1;
        BUS_CLK = 1'b1;
        BUS_DIN = 1'b1;
        man_ack = 1'b0;
        auto_en = 1'b0;
        wait_cyc(3);
        RESET = 1'b0;
        wait_cyc(2);
        chk("rst valid", RX_VALID, 0);
        chk("rst data", RX_DATA, 0);
        chk("rst bcast", RX_BCAST, 0);
        chk("rst end", RX_END, 0);
        chk("rst err", RX_ERR, 0);
        chk("rst ovf", RX_OVF, 0);

        //          addr  nb  bytes       xn xpat   ack  n  b0     b1     end err bc   ovf  vld  data
        vecs[0] = '{4'h3, 2, 24'hA53C00, 0, 8'h00, 1'b1, 2, 8'hA5, 8'h3C, 1, 0, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[1] = '{4'hF, 1, 24'h810000, 0, 8'h00, 1'b1, 1, 8'h81, 8'h00, 1, 0, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[2] = '{4'h7, 1, 24'h810000, 0, 8'h00, 1'b1, 0, 8'h00, 8'h00, 0, 0, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[3] = '{4'h3, 3, 24'h112233, 0, 8'h00, 1'b0, 0, 8'h00, 8'h00, 1, 0, 1'b0, 1'b1, 1'b1, 8'h11};
        vecs[4] = '{4'h3, 1, 24'h550000, 5, 8'hB0, 1'b1, 2, 8'h11, 8'h55, 1, 1, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[5] = '{4'hF, 2, 24'h00FF00, 0, 8'h00, 1'b1, 2, 8'h00, 8'hFF, 1, 0, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[6] = '{4'h0, 1, 24'h5A0000, 0, 8'h00, 1'b1, 0, 8'h00, 8'h00, 0, 0, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[7] = '{4'hF, 0, 24'h000000, 3, 8'hA0, 1'b1, 0, 8'h00, 8'h00, 1, 1, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[8] = '{4'h3, 0, 24'h000000, 0, 8'h00, 1'b1, 0, 8'h00, 8'h00, 1, 0, 1'b0, 1'b0, 1'b0, 8'h00};
        post_rst = '{4'h3, 1, 24'h5A0000, 0, 8'h00, 1'b1, 1, 8'h5A, 8'h00, 1, 0, 1'b0, 1'b0, 1'b0, 8'h00};

        for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("v%0d", i));

        // Ack lands on the exact cycle byte 2 completes: byte taken, no overflow.
        auto_en = 1'b0;
        wait_cyc(8);
        send_head(4'h3);
        send_bits(8'h11, 8);
        send_bits(8'h22, 7);
        BUS_CLK = 1'b0;
        BUS_DIN = 1'b0;
        wait_cyc(H);
        BUS_CLK = 1'b1;
        wait_cyc(2);
        man_ack = 1'b1;
        wait_cyc(1);
        man_ack = 1'b0;
        chk("coinc valid", RX_VALID, 1);
        chk("coinc data", RX_DATA, 8'h22);
        chk("coinc ovf", RX_OVF, 0);
        wait_cyc(H - 3);
        send_tail();
        // Unacked byte survives end and another message start.
        send_msg(4'h7, 1, 24'h990000, 0, 8'h00);
        chk("survive valid", RX_VALID, 1);
        chk("survive data", RX_DATA, 8'h22);
        man_ack = 1'b1;
        wait_cyc(1);
        man_ack = 1'b0;
        chk("ack drop valid", RX_VALID, 0);

        // Reset during bit 4 of a data byte, with an unacked byte pending.
        wait_cyc(8);
        send_head(4'h3);
        send_bits(8'hAA, 8);
        chk("pre-rst valid", RX_VALID, 1);
        chk("pre-rst data", RX_DATA, 8'hAA);
        send_bits(8'hE0, 3);
        BUS_CLK = 1'b0;
        BUS_DIN = 1'b0;
        wait_cyc(3);
        RESET = 1'b1;
        wait_cyc(1);
        RESET = 1'b0;
        chk("midrst valid", RX_VALID, 0);
        chk("midrst data", RX_DATA, 0);
        chk("midrst bcast", RX_BCAST, 0);
        chk("midrst end", RX_END, 0);
        chk("midrst err", RX_ERR, 0);
        chk("midrst ovf", RX_OVF, 0);
        BUS_DIN = 1'b1;
        BUS_CLK = 1'b1;
        wait_cyc(60);
        run_vec(post_rst, "postrst");

        // Clock held high END_IDLE-2 cycles mid-byte must not end the message.
        auto_en = 1'b1;
        q0 = rxq.size();
        e0 = end_cnt;
        r0 = err_cnt;
        wait_cyc(8);
        send_head(4'h3);
        send_bits(8'hC0, 3);
        send_bit(1'b0, END_IDLE - 2);
        send_bits(8'h30, 4);
        send_tail();
        chk("glitch nrx", rxq.size() - q0, 1);
        if (rxq.size() > q0) chk("glitch byte", rxq[q0], 8'hC3);
        chk("glitch end", end_cnt - e0, 1);
        chk("glitch err", err_cnt - r0, 0);
        auto_en = 1'b0;

        // Data low while clock low in IDLE is not a start (RX_BCAST kept).
        send_msg(4'hF, 0, 24'h0, 0, 8'h00);
        chk("bc before", RX_BCAST, 1);
        e0 = end_cnt;
        BUS_CLK = 1'b0;
        wait_cyc(3);
        BUS_DIN = 1'b0;
        wait_cyc(20);
        BUS_DIN = 1'b1;
        wait_cyc(4);
        BUS_CLK = 1'b1;
        wait_cyc(60);
        chk("nostart bcast", RX_BCAST, 1);
        chk("nostart end", end_cnt - e0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
